// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing controller.
// Holds the state enum, opcode constants, mux select encodings and the legal-opcode check.
package multicycle_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam int unsigned TIMER_W = 8;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_IMM, OP_LUI,
            OP_REG, OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive unacknowledged memory request cycles.
// expired flags the cycle in which the count has reached WAIT_MAX and ready is still low.
module mem_wait_timer
    import multicycle_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!req || ready) begin
            count <= '0;
        end else if (count != TIMER_W'(WAIT_MAX)) begin
            count <= count + TIMER_W'(1);
        end
    end

    // ready in the limit cycle still wins over the timeout
    assign expired = req && !ready && (count == TIMER_W'(WAIT_MAX));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the shared RV32I datapath.
// Strobes are decoded from the current state and latched opcode; only state and op_q are stored.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       reg_we,
    output logic [1:0] result_src,
    output logic       instr_done,
    output logic       fault,
    output logic [2:0] state_o
);

    state_t     state;
    state_t     state_next;
    logic [6:0] op_q;
    logic       wait_req;
    logic       expired;

    // Request cycles are exactly the FETCH and MEM states
    assign wait_req = !rst && ((state == FETCH) || (state == MEM));
    assign state_o  = rst ? 3'd0 : 3'(state);

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .req     (wait_req),
        .ready   (mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            op_q  <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                op_q <= op;
            end
        end
    end

    // Next state and strobe decode; everything forced low while rst is high
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_PLUS4;
        reg_we     = 1'b0;
        result_src = RES_ALU;
        instr_done = 1'b0;
        fault      = 1'b0;
        if (!rst) begin
            unique case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we      = 1'b1;
                        state_next = DECODE;
                    end else if (expired) begin
                        state_next = FAULT;
                    end
                end
                DECODE: begin
                    state_next = is_legal(op) ? EXEC : FAULT;
                end
                EXEC: begin
                    if (op_q == OP_BRANCH) begin
                        pc_we      = 1'b1;
                        pc_sel     = zero ? PC_IMM : PC_PLUS4;
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
                        state_next = MEM;
                    end else begin
                        state_next = WB;
                    end
                end
                MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (op_q == OP_STORE);
                    if (mem_ready) begin
                        if (op_q == OP_STORE) begin
                            pc_we      = 1'b1;
                            instr_done = 1'b1;
                            state_next = FETCH;
                        end else begin
                            state_next = WB;
                        end
                    end else if (expired) begin
                        state_next = FAULT;
                    end
                end
                WB: begin
                    reg_we     = 1'b1;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    state_next = FETCH;
                    if (op_q == OP_LOAD) begin
                        result_src = RES_LOAD;
                    end else if ((op_q == OP_JAL) || (op_q == OP_JALR)) begin
                        result_src = RES_PC4;
                    end
                    if (op_q == OP_JAL) begin
                        pc_sel = PC_IMM;
                    end else if (op_q == OP_JALR) begin
                        pc_sel = PC_ALU;
                    end
                end
                FAULT: begin
                    fault = 1'b1;
                end
                default: begin
                    state_next = FAULT;
                end
            endcase
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencing FSM for the RV32I core. It steps one instruction at a time through FETCH/DECODE/EXEC/MEM/WB. It drives the write enables, PC-source select and result-source select for the shared datapath, and the request handshake to a single unified memory port. It replaces per-cycle decode-only control when the datapath is shared across cycles, and sits beside the existing decoder, which still supplies ImmSrc/ALU control.

Parameters:
WAIT_MAX, 15, maximum consecutive cycles mem_req may stay unacknowledged before entering FAULT (1..255).

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
op  in  7  opcode field of the instruction register (valid from DECODE onward)
zero  in  1  branch-condition result from ALU, sampled in EXEC
mem_ready  in  1  memory acknowledges the current request this cycle
mem_req  out  1  memory access request
mem_we  out  1  store request (qualifies mem_req)
ir_we  out  1  load instruction register
pc_we  out  1  update PC this cycle
pc_sel  out  2  00 PC+4, 01 PC+imm, 10 ALU result (JALR, bit0 cleared by datapath)
reg_we  out  1  register-file write
result_src  out  2  00 ALU, 01 load data, 10 PC+4
instr_done  out  1  one-cycle pulse in the instruction's final cycle
fault  out  1  sticky; illegal opcode or memory timeout
state_o  out  3  current state encoding (debug)

Behaviour:
- Reset: while rst=1 every output is 0. State is FETCH, op_q=0, timer=0, fault=0. mem_req rises in the first cycle after rst falls.
- Outputs are Moore-style: decoded from state and op_q, plus mem_ready/zero where noted. No output is registered beyond the state.
- FETCH: mem_req=1, mem_we=0. On mem_ready: ir_we=1, go to DECODE. Otherwise stay.
- DECODE: latch op into op_q. A legal opcode (0000011, 0100011, 0010011, 0110111, 0110011, 1100011, 1101111, 1100111) goes to EXEC. Any other opcode goes to FAULT.
- EXEC, branch: pc_we=1, pc_sel = zero ? 01 : 00, instr_done=1, go to FETCH.
- EXEC, load/store: go to MEM.
- EXEC, all other opcodes: go to WB.
- MEM, load: mem_req=1. On mem_ready go to WB.
- MEM, store: mem_req=1, mem_we=1. On mem_ready: pc_we=1, pc_sel=00, instr_done=1, go to FETCH.
- WB: reg_we=1, pc_we=1, instr_done=1, then go to FETCH.
  - result_src: 01 for load; 10 for JAL/JALR; 00 otherwise.
  - pc_sel: 01 for JAL; 10 for JALR; 00 otherwise.
- Cycle counts with zero-wait memory (mem_ready same cycle as request):
  - branch: 3
  - store: 4
  - R/I/U/JAL/JALR: 4
  - load: 5
- Timer:
  - Counts cycles with mem_req=1 and mem_ready=0; clears on mem_ready or on leaving FETCH/MEM.
  - When the count equals WAIT_MAX and mem_ready is still 0, go to FAULT next cycle.
  - mem_ready in that same cycle wins: normal progress, no fault.
- FAULT: all strobes 0, fault=1. The FSM stays in FAULT until rst.
- rst asserted mid-instruction (including mid-MEM) aborts immediately. No partial pc_we/reg_we is issued in the reset cycle.
- At most one of pc_we/ir_we is active in any cycle. reg_we occurs only in WB.

Decomposition:
- multicycle_pkg:
  - state_t enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5
  - opcode localparams: OP_LOAD, OP_STORE, OP_IMM, OP_LUI, OP_REG, OP_BRANCH, OP_JAL, OP_JALR
  - pc_sel and result_src encodings
- One sub-module, mem_wait_timer: the WAIT_MAX counter, with inputs req/ready and output expired.

Test Plan:
- Reset then ADDI (op 0010011), mem_ready tied 1 -> states FETCH,DECODE,EXEC,WB; WB cycle has reg_we=1, result_src=00, pc_we=1, pc_sel=00, instr_done=1; back in FETCH on cycle 5.
- LW (0000011) with mem_ready delayed 2 cycles in FETCH and 3 in MEM -> ir_we on the 3rd FETCH cycle; WB has result_src=01; instr_done exactly once.
- BEQ (1100011), once with zero=1 and once with zero=0 -> EXEC pc_we=1 with pc_sel=01, then 00; reg_we never asserted; 3 cycles each.
- JALR (1100111) then SW (0100011) -> JALR WB has pc_sel=10 and result_src=10; SW MEM has mem_req=mem_we=1, no reg_we, pc_we on the ready cycle.
- Opcode 0000000 -> DECODE goes to FAULT, fault=1, no strobes for 20 further cycles; rst pulse returns to FETCH with fault=0.
- mem_ready held 0 in FETCH with WAIT_MAX=15 -> FAULT entered after 16 request cycles. Repeat with mem_ready=1 in the 16th cycle -> no fault, DECODE follows.
